// File: rtl/ram_bist.sv
`default_nettype none
// ============================================================================
// ram_bist : four-phase march BIST (up/down, true/inverted) over a 256x8 RAM,
//            each access SETUP/STROBE/HOLD.                      Rev 1.0
// ============================================================================
module ram_bist (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_addr,
   output logic [7:0] fail_data,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   output logic       mem_re,
   input  logic [7:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR_UP = 3'd1,
      RD_UP = 3'd2,
      WR_DN = 3'd3,
      RD_DN = 3'd4,
      DONE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      S_SETUP  = 2'd0,
      S_STROBE = 2'd1,
      S_HOLD   = 2'd2
   } step_t;

   localparam logic [7:0] PATTERN = 8'hA5;

   state_t     state_q, state_d;
   step_t      step_q, step_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [7:0] fail_addr_q, fail_addr_d;
   logic [7:0] fail_data_q, fail_data_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       we_q, we_d;
   logic       re_q, re_d;

   logic       is_wr;
   logic       is_dn;
   logic [7:0] addr_next;
   logic [7:0] addr_term;

   function automatic logic [7:0] pattern_of(input logic [7:0] a, input logic inv);
      pattern_of = inv ? ~(a ^ PATTERN) : (a ^ PATTERN);
   endfunction

   // Down phases are also the inverted-data phases, so one flag serves both.
   assign is_wr     = (state_q == WR_UP) || (state_q == WR_DN);
   assign is_dn     = (state_q == WR_DN) || (state_q == RD_DN);
   assign addr_next = is_dn ? (addr_q - 8'd1) : (addr_q + 8'd1);
   assign addr_term = is_dn ? 8'h00 : 8'hFF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         step_q      <= S_SETUP;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_addr_q <= 8'h00;
         fail_data_q <= 8'h00;
         addr_q      <= 8'h00;
         wdata_q     <= 8'h00;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         re_q        <= re_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = 1'b0;
      re_d        = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = WR_UP;
               step_d      = S_SETUP;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               fail_addr_d = 8'h00;
               fail_data_d = 8'h00;
               addr_d      = 8'h00;
               wdata_d     = pattern_of(8'h00, 1'b0);
            end
         end

         WR_UP, RD_UP, WR_DN, RD_DN: begin
            case (step_q)
               S_SETUP: begin
                  step_d = S_STROBE;
                  we_d   = is_wr;
                  re_d   = !is_wr;
               end
               S_STROBE: begin
                  step_d = S_HOLD;
               end
               default: begin
                  step_d = S_SETUP;
                  // During reads wdata_q carries the expected value.
                  if (!is_wr && (mem_rdata != wdata_q)) begin
                     state_d     = DONE;
                     busy_d      = 1'b0;
                     done_d      = 1'b1;
                     pass_d      = 1'b0;
                     fail_addr_d = addr_q;
                     fail_data_d = mem_rdata;
                  end else if (addr_q == addr_term) begin
                     case (state_q)
                        WR_UP: begin
                           state_d = RD_UP;
                           addr_d  = 8'h00;
                           wdata_d = pattern_of(8'h00, 1'b0);
                        end
                        RD_UP: begin
                           state_d = WR_DN;
                           addr_d  = 8'hFF;
                           wdata_d = pattern_of(8'hFF, 1'b1);
                        end
                        WR_DN: begin
                           state_d = RD_DN;
                           addr_d  = 8'hFF;
                           wdata_d = pattern_of(8'hFF, 1'b1);
                        end
                        default: begin
                           state_d = DONE;
                           busy_d  = 1'b0;
                           done_d  = 1'b1;
                           pass_d  = 1'b1;
                        end
                     endcase
                  end else begin
                     addr_d  = addr_next;
                     wdata_d = pattern_of(addr_next, is_dn);
                  end
               end
            endcase
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = we_q;
   assign mem_re    = re_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist.sv
`default_nettype none
// ============================================================================
// tb_ram_bist : scoreboard bench for ram_bist with a behavioural RAM model.
//               Rev 1.0
// ============================================================================
module tb_ram_bist;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] fail_addr;
   logic [7:0] fail_data;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic       mem_re;
   logic [7:0] mem_rdata;

   ram_bist dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model; optional bit0 stuck-at-1 on one address
   logic [7:0] mem [256];
   logic [7:0] ram_q;
   logic       fault_en;
   logic [7:0] fault_addr;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) ram_q <= (fault_en && mem_addr == fault_addr) ? (mem[mem_addr] | 8'h01)
                                                               : mem[mem_addr];
   end
   assign mem_rdata = ram_q;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       pass;
      logic [7:0] fa;
      logic [7:0] fd;
      int         cyc;
      int         nwe;
      int         nre;
   } exp_t;

   exp_t sb[$];

   // ---------------- monitor: protocol + scoreboard ----------------
   logic       prev_we = 1'b0, prev_re = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
   logic [7:0] prev_addr = 8'h00, prev_wdata = 8'h00;
   int         n_we = 0, n_re = 0;
   logic [7:0] m_addr, m_data;
   exp_t       m_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_we = 1'b0;
         prev_re = 1'b0;
      end else begin
         if (busy && !prev_busy) begin
            n_we = 0;
            n_re = 0;
         end
         chk("we_re_exclusive", {63'd0, mem_we & mem_re}, 64'd0);
         chk("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
         if (mem_we || mem_re) begin
            chk("strobe_while_not_busy", {63'd0, !busy}, 64'd0);
            chk("setup_addr_stable", mem_addr, prev_addr);
            chk("setup_wdata_stable", mem_wdata, prev_wdata);
         end
         if (prev_we || prev_re) begin
            chk("hold_addr_stable", mem_addr, prev_addr);
            chk("hold_wdata_stable", mem_wdata, prev_wdata);
         end
         if (mem_we) begin
            chk("we_width", {63'd0, prev_we}, 64'd0);
            if (n_we < 256) begin
               m_addr = n_we[7:0];
               m_data = m_addr ^ 8'hA5;
            end else begin
               m_addr = 8'(511 - n_we);
               m_data = ~(m_addr ^ 8'hA5);
            end
            chk("write_addr", mem_addr, m_addr);
            chk("write_data", mem_wdata, m_data);
            if (n_we == 0)   chk("wr_up_0x00_data", mem_wdata, 8'hA5);
            if (n_we == 16)  chk("wr_up_0x10_data", {mem_addr, mem_wdata}, 16'h10B5);
            if (n_we == 256) chk("wr_dn_0xff_data", {mem_addr, mem_wdata}, 16'hFFA5);
            if (n_we == 511) chk("wr_dn_0x00_data", {mem_addr, mem_wdata}, 16'h005A);
            n_we++;
         end
         if (mem_re) begin
            chk("re_width", {63'd0, prev_re}, 64'd0);
            m_addr = (n_re < 256) ? n_re[7:0] : 8'(511 - n_re);
            chk("read_addr", mem_addr, m_addr);
            n_re++;
         end
         if (done && !prev_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               m_e = sb.pop_front();
               chk("result_pass", {63'd0, pass}, {63'd0, m_e.pass});
               chk("result_fail_addr", fail_addr, m_e.fa);
               chk("result_fail_data", fail_data, m_e.fd);
               chk("result_cycle", cyc, m_e.cyc);
               chk("result_we_pulses", n_we, m_e.nwe);
               chk("result_re_pulses", n_re, m_e.nre);
            end
         end
      end
      prev_we    = mem_we;
      prev_re    = mem_re;
      prev_busy  = busy;
      prev_done  = done;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
   end

   // ---------------- stimulus ----------------
   logic [36:0] idle_vec;
   assign idle_vec = {busy, done, pass, mem_we, mem_re, fail_addr, fail_data, mem_addr, mem_wdata};

   task automatic issue(input bit push, input logic xpass, input logic [7:0] fa,
                        input logic [7:0] fd, input int lat, input int nwe,
                        input int nre, input int hold);
      exp_t e;
      @(negedge clk);
      if (push) begin
         e.pass = xpass;
         e.fa   = fa;
         e.fd   = fd;
         e.cyc  = cyc + 1 + lat;
         e.nwe  = nwe;
         e.nre  = nre;
         sb.push_back(e);
      end
      start = 1'b1;
      @(negedge clk);
      chk("busy_after_start", {done, busy}, 2'b01);
      repeat (hold - 1) @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("done_within_bound", {63'd0, done}, 64'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      fault_en   = 1'b0;
      fault_addr = 8'h37;

      repeat (3) @(negedge clk);
      chk("reset_outputs", idle_vec, 37'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_after_release", idle_vec, 37'd0);

      // fault-free run
      issue(1'b1, 1'b1, 8'h00, 8'h00, 3072, 512, 512, 1);
      wait_done();

      // stuck-at fault at 0x37: mismatch during RD_UP
      fault_en = 1'b1;
      issue(1'b1, 1'b0, 8'h37, 8'h93, 936, 256, 56, 1);
      wait_done();
      repeat (20) @(negedge clk);
      chk("fault_result_held", {done, pass, busy, mem_we, mem_re}, 5'b10000);
      fault_en = 1'b0;

      // start held high for 100 cycles while busy
      issue(1'b1, 1'b1, 8'h00, 8'h00, 3072, 512, 512, 100);
      wait_done();

      // restart directly from DONE
      issue(1'b1, 1'b1, 8'h00, 8'h00, 3072, 512, 512, 1);
      wait_done();

      // reset during a RD_UP STROBE cycle (read of address 0x0A)
      issue(1'b0, 1'b0, 8'h00, 8'h00, 0, 0, 0, 1);
      repeat (799) @(posedge clk);
      #1;
      chk("read_strobe_before_reset", {busy, mem_re, mem_addr}, {2'b11, 8'h0A});
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_drops_strobe", idle_vec, 37'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_after_mid_test_reset", idle_vec, 37'd0);
      end

      // full run after reset recovery
      issue(1'b1, 1'b1, 8'h00, 8'h00, 3072, 512, 512, 1);
      wait_done();

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
